mem_port_sequencer: RTL and testbench
=====================================

Name: mem_port_sequencer

Overview:
- Multi-cycle sequencer that lets the single-cycle core datapath share one memory port between instruction fetch and load/store.
- Fetches each instruction into a held instruction register and performs the data access if the instruction needs one.
- Issues a one-cycle commit strobe that gates the PC update and register-file write.
- Sits between the core datapath and the unified memory.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, instruction/data word width.
- TIMEOUT, 255, maximum wait cycles per memory request; used only with WAIT_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_in  input  ADDR_W  current PC from the datapath.
- d_rd  input  1  decoded load (MemRead) for the held instruction.
- d_wr  input  1  decoded store (MemWrite) for the held instruction.
- d_addr  input  ADDR_W  ALU-computed data address.
- d_wdata  input  DATA_W  store data (register read port 2).
- instr_out  output  DATA_W  held instruction driving the datapath instruction input.
- d_rdata  output  DATA_W  latched load data driving the datapath Memdata input.
- commit  output  1  one-cycle strobe; enables PC load and RegWrite.
- busy  output  1  high in every state except COMMIT.
- retired  output  32  count of committed instructions.
- bus_err  output  1  sticky timeout error.
- mem_req  output  1  memory request.
- mem_we  output  1  write qualifier.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_ack  input  1  memory completion, one cycle.
- mem_rdata  input  DATA_W  memory read data, valid with mem_ack.

Behaviour:
- Reset (async, active-high): state=IDLE, instr_out=0, d_rdata=0, commit=0, retired=0, bus_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- All outputs are registered except busy, which decodes state. Reset asserted mid-access aborts immediately; no memory-side cleanup.
- FSM states: IDLE, FETCH, EXEC, DATA, COMMIT, HALT.
- IDLE: go to FETCH on the next cycle after reset release.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc_in, captured on state entry and held stable until ack. On mem_ack: latch mem_rdata into instr_out, drop mem_req, go to EXEC.
- EXEC: one cycle with no memory activity, so the datapath settles on the new instr_out.
  - Neither d_rd nor d_wr: go to COMMIT.
  - Either asserted: go to DATA.
  - mem_addr, mem_we and mem_wdata are captured at the EXEC->DATA transition.
- DATA:
  - mem_req=1; mem_we=d_wr; mem_addr=d_addr; mem_wdata=d_wdata.
  - If d_rd and d_wr are both high, the store wins and no load data is latched.
  - On mem_ack: for a load, latch mem_rdata into d_rdata. Drop mem_req and go to COMMIT.
- COMMIT: commit=1 for exactly one cycle; retired increments, wrapping 0xFFFFFFFF->0. Next state is FETCH.
- Handshake rules:
  - mem_req stays high, with address and data stable, until mem_ack is sampled.
  - mem_ack arriving in the first request cycle is legal.
  - mem_req is low in the cycle after ack.
  - mem_ack outside FETCH/DATA is ignored.
- d_rdata keeps its value until the next load's ack. instr_out is stable from EXEC through COMMIT.
- Zero-wait latency: 3 cycles for an ALU/branch instruction (FETCH, EXEC, COMMIT); 4 cycles for a load/store (FETCH, EXEC, DATA, COMMIT). Each memory wait cycle adds 1.
- HALT: terminal until reset; mem_req=0, commit=0. Reachable only with WAIT_TIMEOUT_EN.

Optional Feature:
- Macro: WAIT_TIMEOUT_EN.
- Defined:
  - An 8+-bit wait counter clears on entry to FETCH/DATA and increments each cycle without mem_ack.
  - When the count reaches TIMEOUT: drop mem_req, set bus_err=1 (sticky), go to HALT, and do not commit.
- Undefined:
  - No counter is built; a request waits indefinitely.
  - bus_err is tied 0 and HALT is unreachable.

Test Plan:
- Reset release, ALU instruction, mem_ack same cycle as req, rdata=0x00A00093 -> instr_out=0x00A00093 at EXEC; commit high for exactly 1 cycle at cycle 3; retired=1.
- Load: d_rd=1, d_addr=0x40, ack after 2 wait cycles, rdata=0xDEADBEEF -> mem_addr=0x40 and mem_we=0 held during all waits; d_rdata=0xDEADBEEF before commit; 6 cycles total.
- Store: d_wr=1, d_addr=0x44, d_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678 until ack; d_rdata unchanged.
- d_rd=d_wr=1 -> write performed; d_rdata keeps its previous value.
- Reset asserted mid-DATA wait -> mem_req=0 and state IDLE asynchronously; retired=0; next fetch starts 2 cycles after release.
- WAIT_TIMEOUT_EN defined, TIMEOUT=4, mem_ack never asserted in FETCH -> bus_err=1 after 4 cycles; mem_req=0; commit never pulses until reset.

Source files
------------

// File: rtl/mem_port_sequencer.sv
// Shares one memory port between fetch and load/store; 3 cycles per ALU op, 4 per load/store, +1 per mem wait cycle.
// Holds mem_req with stable address/data until mem_ack; optional WAIT_TIMEOUT_EN halts with sticky bus_err after TIMEOUT waits.
module mem_port_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] d_rdata,
    output logic              commit,
    output logic              busy,
    output logic [31:0]       retired,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        DATA   = 3'd3,
        COMMIT = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t state, state_nxt;
    logic   timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH: begin
                if (mem_ack) begin
                    state_nxt = EXEC;
                end else if (timeout_hit) begin
                    state_nxt = HALT;
                end
            end
            EXEC:   state_nxt = (d_rd || d_wr) ? DATA : COMMIT;
            DATA: begin
                if (mem_ack) begin
                    state_nxt = COMMIT;
                end else if (timeout_hit) begin
                    state_nxt = HALT;
                end
            end
            COMMIT: state_nxt = FETCH;
            HALT:   state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != COMMIT);

    // Address/data are captured only on entry to a request state so they stay stable while waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_out <= '0;
            d_rdata   <= '0;
            commit    <= 1'b0;
            retired   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (state_nxt == FETCH) || (state_nxt == DATA);
            commit  <= (state_nxt == COMMIT);

            if (state != FETCH && state_nxt == FETCH) begin
                mem_addr <= pc_in;
                mem_we   <= 1'b0;
            end
            if (state == EXEC && state_nxt == DATA) begin
                mem_addr  <= d_addr;
                mem_we    <= d_wr;
                mem_wdata <= d_wdata;
            end
            if (state == DATA && state_nxt != DATA) begin
                mem_we <= 1'b0;
            end

            if (state == FETCH && mem_ack) begin
                instr_out <= mem_rdata;
            end
            // mem_we already encodes store-wins when both d_rd and d_wr were set.
            if (state == DATA && mem_ack && !mem_we) begin
                d_rdata <= mem_rdata;
            end
            if (state == COMMIT) begin
                retired <= retired + 32'd1;
            end
        end
    end

`ifdef WAIT_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             in_req;

    assign in_req      = (state == FETCH) || (state == DATA);
    assign timeout_hit = in_req && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (in_req && !mem_ack) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (timeout_hit) begin
                bus_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign bus_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: ALU, load, store, store-wins, fetch waits, async reset, timeout.
module tb_mem_port_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] instr_out;
    logic [31:0] d_rdata;
    logic        commit;
    logic        busy;
    logic [31:0] retired;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    mem_port_sequencer #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_in    (pc_in),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .instr_out(instr_out),
        .d_rdata  (d_rdata),
        .commit   (commit),
        .busy     (busy),
        .retired  (retired),
        .bus_err  (bus_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr_out); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", d_rdata); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL rst_commit got %b exp 0", commit); end
        checks++; if (retired !== 32'h0) begin errors++; $display("FAIL rst_retired got %0d exp 0", retired); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err got %b exp 0", bus_err); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", busy); end
        pc_in = 32'h100;
        reset = 1'b0;
        step();
    endtask

    task automatic test_alu();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL alu_req got %b exp 1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL alu_fetch_addr got %h exp 100", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL alu_fetch_we got %b exp 0", mem_we); end
        mem_rdata = 32'h00A00093;
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        checks++; if (instr_out !== 32'h00A00093) begin errors++; $display("FAIL alu_instr got %h exp 00a00093", instr_out); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL alu_req_after_ack got %b exp 0", mem_req); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL alu_commit_exec got %b exp 0", commit); end
        step();
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL alu_commit_c3 got %b exp 1", commit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alu_busy_commit got %b exp 0", busy); end
        pc_in = 32'h104;
        step();
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL alu_commit_width got %b exp 0", commit); end
        checks++; if (retired !== 32'd1) begin errors++; $display("FAIL alu_retired got %0d exp 1", retired); end
        checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL alu_next_fetch got %h exp 104", mem_addr); end
    endtask

    task automatic test_load();
        d_rd = 1'b1; d_wr = 1'b0; d_addr = 32'h40; d_wdata = 32'h0;
        mem_rdata = 32'h04002083;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        for (int w = 0; w < 3; w++) begin
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ld_req w%0d got %b exp 1", w, mem_req); end
            checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL ld_addr w%0d got %h exp 40", w, mem_addr); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ld_we w%0d got %b exp 0", w, mem_we); end
            checks++; if (commit !== 1'b0) begin errors++; $display("FAIL ld_early_commit w%0d got %b exp 0", w, commit); end
            if (w == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEADBEEF;
            end
            step();
        end
        mem_ack = 1'b0;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL ld_commit_c6 got %b exp 1", commit); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata got %h exp deadbeef", d_rdata); end
        checks++; if (instr_out !== 32'h04002083) begin errors++; $display("FAIL ld_instr_hold got %h exp 04002083", instr_out); end
        pc_in = 32'h108;
        step();
        checks++; if (retired !== 32'd2) begin errors++; $display("FAIL ld_retired got %0d exp 2", retired); end
    endtask

    task automatic test_store();
        d_rd = 1'b0; d_wr = 1'b1; d_addr = 32'h44; d_wdata = 32'h12345678;
        checks++; if (mem_addr !== 32'h108) begin errors++; $display("FAIL st_fetch_addr got %h exp 108", mem_addr); end
        mem_rdata = 32'h0020A223;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        for (int w = 0; w < 2; w++) begin
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL st_we w%0d got %b exp 1", w, mem_we); end
            checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL st_wdata w%0d got %h exp 12345678", w, mem_wdata); end
            checks++; if (mem_addr !== 32'h44) begin errors++; $display("FAIL st_addr w%0d got %h exp 44", w, mem_addr); end
            if (w == 1) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end
            step();
        end
        mem_ack = 1'b0;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL st_commit got %b exp 1", commit); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_rdata_kept got %h exp deadbeef", d_rdata); end
        pc_in = 32'h10C;
        step();
        checks++; if (retired !== 32'd3) begin errors++; $display("FAIL st_retired got %0d exp 3", retired); end
    endtask

    task automatic test_both_rd_wr();
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h48; d_wdata = 32'hCAFEF00D;
        mem_rdata = 32'h0060A423;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL both_we got %b exp 1", mem_we); end
        checks++; if (mem_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL both_wdata got %h exp cafef00d", mem_wdata); end
        checks++; if (mem_addr !== 32'h48) begin errors++; $display("FAIL both_addr got %h exp 48", mem_addr); end
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        step();
        mem_ack = 1'b0;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL both_commit got %b exp 1", commit); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL both_rdata_kept got %h exp deadbeef", d_rdata); end
        pc_in = 32'h110;
        d_rd = 1'b0; d_wr = 1'b0;
        step();
        checks++; if (retired !== 32'd4) begin errors++; $display("FAIL both_retired got %0d exp 4", retired); end
    endtask

    task automatic test_fetch_wait();
        for (int w = 0; w < 3; w++) begin
            checks++; if (mem_addr !== 32'h110) begin errors++; $display("FAIL fw_addr w%0d got %h exp 110", w, mem_addr); end
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fw_req w%0d got %b exp 1", w, mem_req); end
            checks++; if (instr_out !== 32'h0060A423) begin errors++; $display("FAIL fw_instr_hold w%0d got %h exp 0060a423", w, instr_out); end
            if (w == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h00208133;
            end
            step();
        end
        mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL fw_commit got %b exp 1", commit); end
        checks++; if (instr_out !== 32'h00208133) begin errors++; $display("FAIL fw_stray_ack got %h exp 00208133", instr_out); end
        pc_in = 32'h114;
        step();
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL fw_commit_width got %b exp 0", commit); end
        checks++; if (retired !== 32'd5) begin errors++; $display("FAIL fw_retired got %0d exp 5", retired); end
    endtask

    task automatic test_reset_mid();
        d_rd = 1'b1; d_addr = 32'h80;
        mem_rdata = 32'h08002103;
        mem_ack   = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_data_req got %b exp 1", mem_req); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_async_req got %b exp 0", mem_req); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rm_retired got %0d exp 0", retired); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL rm_instr got %h exp 0", instr_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy got %b exp 1", busy); end
        step();
        step();
        d_rd   = 1'b0;
        pc_in  = 32'h200;
        reset  = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_idle_cycle got %b exp 0", mem_req); end
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_fetch_cycle2 got %b exp 1", mem_req); end
        checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL rm_fetch_addr got %h exp 200", mem_addr); end
    endtask

`ifdef WAIT_TIMEOUT_EN
    task automatic test_timeout();
        for (int w = 0; w < 4; w++) begin
            checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_early_err c%0d got %b exp 0", w + 1, bus_err); end
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_req c%0d got %b exp 1", w + 1, mem_req); end
            step();
        end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err got %b exp 1", bus_err); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_req_drop got %b exp 0", mem_req); end
        mem_ack = 1'b1;
        for (int w = 0; w < 6; w++) begin
            step();
            checks++; if (commit !== 1'b0) begin errors++; $display("FAIL to_halt_commit c%0d got %b exp 0", w, commit); end
            checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky c%0d got %b exp 1", w, bus_err); end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_halt_req c%0d got %b exp 0", w, mem_req); end
        end
        mem_ack = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        for (int w = 0; w < 20; w++) begin
            step();
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL nt_req c%0d got %b exp 1", w, mem_req); end
            checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL nt_bus_err c%0d got %b exp 0", w, bus_err); end
            checks++; if (commit !== 1'b0) begin errors++; $display("FAIL nt_commit c%0d got %b exp 0", w, commit); end
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        pc_in     = 32'h0;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_both_rd_wr();
        test_fetch_wait();
        test_reset_mid();
`ifdef WAIT_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
